psram_access_arbiter: RTL
=========================

// Module: psram_access_arbiter
// PURPOSE
//  Shares the single PSRAM controller between two requesters: the display
//  refill path (vga_*, read-only bursts) and the MCU bus command path (mcu_*,
//  read or write bursts). It arbitrates, launches one burst at a time and
//  counts bytes. It steers write data to the PSRAM and read data back to the
//  burst owner. It sits between msgpu's requesters and the psram block, on
//  system_clock.
// PARAMETERS
//  ADDRESS_WIDTH  24  PSRAM byte address width
//  LENGTH_WIDTH   8   burst length field; bytes transferred = length + 1
//  MAX_MCU_WAIT   64  cycles an MCU request may lose before it is forced to win
// PORTS
//  system_clock     in   1   single clock for the whole block
//  reset            in   1   synchronous, active-high reset
//  vga_req          in   1   display burst request; held until vga_done
//  vga_address      in   ADDRESS_WIDTH  burst start address; sampled at grant
//  vga_length       in   LENGTH_WIDTH   burst length - 1; sampled at grant
//  vga_grant        out  1   display owns PSRAM
//  vga_rdata        out  8   read byte
//  vga_rdata_valid  out  1   vga_rdata valid this cycle
//  vga_done         out  1   one-cycle burst-complete pulse
//  mcu_req          in   1   MCU burst request; held until mcu_done
//  mcu_rw           in   1   1 = write, 0 = read; sampled at grant
//  mcu_address      in   ADDRESS_WIDTH  burst start address; sampled at grant
//  mcu_length       in   LENGTH_WIDTH   burst length - 1; sampled at grant
//  mcu_wdata        in   8   current write byte
//  mcu_wdata_ready  out  1   current mcu_wdata consumed; present next byte
//  mcu_grant        out  1   MCU owns PSRAM
//  mcu_rdata        out  8   read byte
//  mcu_rdata_valid  out  1   mcu_rdata valid this cycle
//  mcu_done         out  1   one-cycle burst-complete pulse
//  psram_start      out  1   one-cycle pulse: launch burst with rw/address
//  psram_rw         out  1   1 = write
//  psram_address    out  ADDRESS_WIDTH  latched burst address
//  psram_wdata      out  8   = mcu_wdata (combinational) while MCU write owns bus, else 0
//  psram_rdata      in   8   byte from PSRAM controller
//  psram_byte_strobe in  1   PSRAM consumed (write) or produced (read) one byte
//  psram_busy       in   1   PSRAM controller still active (CE low)
// BEHAVIOUR
//  Reset:
//   - All outputs 0; FSM = IDLE; byte and wait counters 0.
//   - Reset mid-burst abandons the burst; no done pulse is emitted.
//  FSM:
//   - IDLE  -> START on any req (arbitration below). Grant and latched
//     rw/address/length are registered, visible in START.
//   - START -> XFER: psram_start = 1 for exactly this cycle.
//   - XFER: each psram_byte_strobe increments byte_count. The strobe with
//     byte_count == length -> DRAIN.
//   - DRAIN -> IDLE in the first cycle psram_busy = 0 is sampled.
//   - On entry to IDLE: owner's done = 1 for one cycle; grant = 0 from that cycle.
//  Arbitration (evaluated in IDLE only; req ignored in the done cycle):
//   - vga wins by default, including when both requests are simultaneous.
//   - mcu wins if mcu_req = 1 and wait_count == MAX_MCU_WAIT.
//  Starvation counter:
//   - wait_count increments on every cycle mcu_req = 1 and mcu_grant = 0.
//   - Saturates at MAX_MCU_WAIT; clears on mcu grant.
//  Latency:
//   - req sampled in IDLE at cycle N: grant at N+1, psram_start at N+1.
//   - Minimum one IDLE cycle between bursts.
//  Data steering:
//   - Reads: owner rdata_valid = psram_byte_strobe in XFER; rdata = psram_rdata.
//     The non-owner's rdata/rdata_valid = 0.
//   - MCU write: mcu_wdata_ready = psram_byte_strobe in XFER.
//   - Strobes outside XFER are ignored. Exactly length+1 strobes are forwarded.
//  Other rules:
//   - Dropping req mid-burst does not abort; the burst completes and done pulses.
//   - vga_rw is implicitly 0.
//   - length = all-ones gives 2^LENGTH_WIDTH bytes; byte_count is LENGTH_WIDTH
//     bits and wraps only at completion.
// TESTING
//  1. vga_req at cycle 10, addr 0x001000, len 3; PSRAM model gives 4 strobes
//     -> vga_grant and psram_start at cycle 11; 4 vga_rdata_valid; vga_done once;
//     psram_rw = 0.
//  2. vga_req and mcu_req rise in the same cycle -> vga granted first; mcu granted
//     at the IDLE cycle after vga_done+1.
//  3. MCU write, addr 0xABCDEF, len 0xFF, wdata = byte index -> 256 wdata_ready
//     pulses; PSRAM model receives 0x00..0xFF in order; mcu_done once.
//  4. vga_req held high continuously and mcu_req pending -> mcu granted at the
//     first IDLE after wait_count reaches 64; vga resumes afterwards.
//  5. Reset asserted during XFER of an MCU burst -> next cycle all outputs 0,
//     no mcu_done; a fresh vga_req is served normally.
//  6. Stray psram_byte_strobe in IDLE/DRAIN, and psram_busy held high 5 cycles
//     after the last byte -> strobes not forwarded; done delayed until busy = 0.

Source files
------------

// File: rtl/psram_access_arbiter_if.sv
// ----------------------------------------------------------------------------
// psram_access_arbiter_if
//   Bundles every handshake/bus signal around the PSRAM access arbiter.
//   slave  : arbiter side (takes requests, drives grants and PSRAM commands)
//   master : surrounding side (display refill, MCU bus and PSRAM controller)
//   Signal groups:
//     vga_*   display read-burst requester
//     mcu_*   MCU read/write-burst requester
//     psram_* command/data path to the PSRAM controller
// ----------------------------------------------------------------------------
interface psram_access_arbiter_if #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int LENGTH_WIDTH  = 8
);
    logic                     vga_req;
    logic [ADDRESS_WIDTH-1:0] vga_address;
    logic [LENGTH_WIDTH-1:0]  vga_length;
    logic                     vga_grant;
    logic [7:0]               vga_rdata;
    logic                     vga_rdata_valid;
    logic                     vga_done;

    logic                     mcu_req;
    logic                     mcu_rw;
    logic [ADDRESS_WIDTH-1:0] mcu_address;
    logic [LENGTH_WIDTH-1:0]  mcu_length;
    logic [7:0]               mcu_wdata;
    logic                     mcu_wdata_ready;
    logic                     mcu_grant;
    logic [7:0]               mcu_rdata;
    logic                     mcu_rdata_valid;
    logic                     mcu_done;

    logic                     psram_start;
    logic                     psram_rw;
    logic [ADDRESS_WIDTH-1:0] psram_address;
    logic [7:0]               psram_wdata;
    logic [7:0]               psram_rdata;
    logic                     psram_byte_strobe;
    logic                     psram_busy;

    modport slave (
        input  vga_req, vga_address, vga_length,
        output vga_grant, vga_rdata, vga_rdata_valid, vga_done,
        input  mcu_req, mcu_rw, mcu_address, mcu_length, mcu_wdata,
        output mcu_wdata_ready, mcu_grant, mcu_rdata, mcu_rdata_valid, mcu_done,
        output psram_start, psram_rw, psram_address, psram_wdata,
        input  psram_rdata, psram_byte_strobe, psram_busy
    );

    modport master (
        output vga_req, vga_address, vga_length,
        input  vga_grant, vga_rdata, vga_rdata_valid, vga_done,
        output mcu_req, mcu_rw, mcu_address, mcu_length, mcu_wdata,
        input  mcu_wdata_ready, mcu_grant, mcu_rdata, mcu_rdata_valid, mcu_done,
        input  psram_start, psram_rw, psram_address, psram_wdata,
        output psram_rdata, psram_byte_strobe, psram_busy
    );
endinterface

// File: rtl/psram_access_arbiter.sv
// ----------------------------------------------------------------------------
// psram_access_arbiter
//   Shares one PSRAM controller between the display refill path (read bursts)
//   and the MCU command path (read or write bursts). One burst at a time:
//   IDLE -> START (psram_start pulse) -> XFER (count length+1 byte strobes)
//   -> DRAIN (wait for controller idle) -> IDLE (owner's done pulse).
//   The display wins by default; an MCU request that has waited
//   MAX_MCU_WAIT cycles is forced through at the next arbitration.
//   Ports:
//     system_clock  single clock
//     reset         synchronous, active-high
//     bus           psram_access_arbiter_if.slave (requesters + PSRAM side)
// ----------------------------------------------------------------------------
module psram_access_arbiter #(
    parameter int ADDRESS_WIDTH = 24,
    parameter int LENGTH_WIDTH  = 8,
    parameter int MAX_MCU_WAIT  = 64
) (
    input  logic                         system_clock,
    input  logic                         reset,
    psram_access_arbiter_if.slave        bus
);
    localparam int WAIT_WIDTH = $clog2(MAX_MCU_WAIT + 1);

    typedef enum logic [1:0] {IDLE, START, XFER, DRAIN} state_t;

    state_t                   state, state_next;
    logic [LENGTH_WIDTH-1:0]  byte_count, length_q;
    logic [WAIT_WIDTH-1:0]    wait_count;
    logic [ADDRESS_WIDTH-1:0] address_q;
    logic                     rw_q;
    logic                     vga_grant_q, mcu_grant_q;
    logic                     vga_done_q, mcu_done_q;

    logic pick_vga, pick_mcu;
    logic strobe_in_xfer, last_byte, mcu_starved, done_cycle, mcu_write;

    // The done pulse marks the first IDLE cycle after a burst; requests are
    // not looked at then, which guarantees one idle cycle between bursts.
    assign done_cycle  = vga_done_q | mcu_done_q;
    assign mcu_starved = bus.mcu_req && (wait_count == WAIT_WIDTH'(MAX_MCU_WAIT));

    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        state_next     = state;
        pick_vga       = 1'b0;
        pick_mcu       = 1'b0;
        strobe_in_xfer = (state == XFER) && bus.psram_byte_strobe;
        last_byte      = strobe_in_xfer && (byte_count == length_q);
        case (state)
            IDLE: begin
                if (!done_cycle) begin
                    if (mcu_starved)      pick_mcu = 1'b1;
                    else if (bus.vga_req) pick_vga = 1'b1;
                    else if (bus.mcu_req) pick_mcu = 1'b1;
                end
                if (pick_vga || pick_mcu) state_next = START;
            end
            START:   state_next = XFER;
            XFER:    if (last_byte) state_next = DRAIN;
            DRAIN:   if (!bus.psram_busy) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge system_clock) begin
        // NOTE: non-blocking assignments for all state, so every update below
        // sees the values from before this clock edge regardless of order.
        if (reset) begin
            state       <= IDLE;
            byte_count  <= '0;
            length_q    <= '0;
            wait_count  <= '0;
            address_q   <= '0;
            rw_q        <= 1'b0;
            vga_grant_q <= 1'b0;
            mcu_grant_q <= 1'b0;
            vga_done_q  <= 1'b0;
            mcu_done_q  <= 1'b0;
        end else begin
            state      <= state_next;
            vga_done_q <= 1'b0;
            mcu_done_q <= 1'b0;

            if (pick_vga || pick_mcu) begin
                vga_grant_q <= pick_vga;
                mcu_grant_q <= pick_mcu;
                rw_q        <= pick_mcu && bus.mcu_rw;    // display never writes
                address_q   <= pick_mcu ? bus.mcu_address : bus.vga_address;
                length_q    <= pick_mcu ? bus.mcu_length  : bus.vga_length;
                byte_count  <= '0;
            end

            // Wraps back to zero only on the final byte, so an all-ones
            // length moves 2^LENGTH_WIDTH bytes.
            if (strobe_in_xfer) byte_count <= last_byte ? '0 : byte_count + 1'b1;

            if (state == DRAIN && !bus.psram_busy) begin
                vga_done_q  <= vga_grant_q;
                mcu_done_q  <= mcu_grant_q;
                vga_grant_q <= 1'b0;
                mcu_grant_q <= 1'b0;
            end

            if (pick_mcu)
                wait_count <= '0;
            else if (bus.mcu_req && !mcu_grant_q &&
                     wait_count != WAIT_WIDTH'(MAX_MCU_WAIT))
                wait_count <= wait_count + 1'b1;
        end
    end

    assign mcu_write = mcu_grant_q && rw_q;

    assign bus.vga_grant       = vga_grant_q;
    assign bus.mcu_grant       = mcu_grant_q;
    assign bus.vga_done        = vga_done_q;
    assign bus.mcu_done        = mcu_done_q;
    assign bus.psram_start     = (state == START);
    assign bus.psram_rw        = rw_q;
    assign bus.psram_address   = address_q;
    assign bus.psram_wdata     = mcu_write ? bus.mcu_wdata : 8'h00;
    assign bus.mcu_wdata_ready = strobe_in_xfer && mcu_write;
    assign bus.vga_rdata_valid = strobe_in_xfer && vga_grant_q;
    assign bus.mcu_rdata_valid = strobe_in_xfer && mcu_grant_q && !rw_q;
    assign bus.vga_rdata       = bus.vga_rdata_valid ? bus.psram_rdata : 8'h00;
    assign bus.mcu_rdata       = bus.mcu_rdata_valid ? bus.psram_rdata : 8'h00;
endmodule
